pusch_cp_insert: RTL and testbench

- Cyclic-prefix insertion stage directly downstream of the PUSCH IFFT output (Data_r/Data_i/Data_valid).
- Buffers each NFFT-sample time-domain symbol in a ping-pong RAM, then emits the CP (last CP samples) followed by the full symbol.
- Symbols 0 and SYMS_PER_HALF of each slot get the extended CP (CP_LEN+CP_EXT), as for 15 kHz normal CP.
- Output feeds the PUSCH sample interface to the DAC/front-end.

---
 rtl/pusch_cp_pkg.sv | 16 +
 rtl/pusch_cp_bank_ram.sv | 21 ++
 rtl/pusch_cp_insert.sv | 211 +++++++++++++++++++++
 tb/tb_pusch_cp_insert.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/pusch_cp_pkg.sv
// Shared types and default sizing for the PUSCH cyclic-prefix insertion stage.
package pusch_cp_pkg;
  localparam int WIDTH  = 26;
  localparam int NFFT   = 1024;
  localparam int CP_LEN = 72;
  localparam int CP_EXT = 8;
  localparam int PTR_W  = $clog2(NFFT);
  localparam int CPW    = $clog2(CP_LEN + CP_EXT + 1);

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } sample_t;

  typedef enum logic [1:0] {IDLE, CP, BODY} rd_state_e;
endpackage

// File: rtl/pusch_cp_bank_ram.sv
// Ping-pong symbol store: one write port, one read port, bank bit is the address MSB.
module pusch_cp_bank_ram #(
  parameter int DW = 52,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [2**AW];

  // Registered write and registered (1-cycle latency) read.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/pusch_cp_insert.sv
// Buffers IFFT symbols in a ping-pong RAM and replays each as CP tail + full symbol.
module pusch_cp_insert #(
  parameter int WIDTH         = 26,
  parameter int NFFT          = 1024,
  parameter int CP_LEN        = 72,
  parameter int CP_EXT        = 8,
  parameter int SYMS_PER_SLOT = 14,
  parameter int SYMS_PER_HALF = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    slot_sync,
  input  logic                    Data_valid_in,
  input  logic signed [WIDTH-1:0] Data_r_in,
  input  logic signed [WIDTH-1:0] Data_i_in,
  output logic                    Data_valid,
  output logic signed [WIDTH-1:0] Data_r,
  output logic signed [WIDTH-1:0] Data_i,
  output logic                    sym_first,
  output logic                    overflow
);
  import pusch_cp_pkg::*;

  localparam int AW = $clog2(NFFT);
  localparam int CW = $clog2(CP_LEN + CP_EXT + 1);
  localparam int SW = $clog2(SYMS_PER_SLOT);
  localparam logic [CW-1:0] CP_S = CW'(CP_LEN);
  localparam logic [CW-1:0] CP_L = CW'(CP_LEN + CP_EXT);
  localparam logic [AW-1:0] LAST = AW'(NFFT - 1);

  // writer state
  logic [AW-1:0] wr_ptr_q;
  logic          wr_bank_q;
  logic [1:0]    full_q, full_d;
  logic [CW-1:0] cp_len_q [2];
  logic [SW-1:0] sym_idx_q;
  logic          sync_pend_q;
  logic          overflow_q;
  logic          wr_acc, wr_drop, wr_last;
  logic [CW-1:0] cp_cur;

  // reader state
  rd_state_e     st_q, st_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, rd_addr;
  logic          rd_bank_q, rd_bank_d;
  logic          first_pend_q, first_pend_d;
  logic          rd_en, rd_first, rd_clr;
  logic [1:0]    avail;
  logic [CW-1:0] cp_av [2];
  logic [AW-1:0] start_rd, start_nxt;

  // output pipeline
  logic [2:1]          vld_pipe_q, first_pipe_q;
  logic [2*WIDTH-1:0]  rdata;
  sample_t             dout_q;

  assign wr_acc  = Data_valid_in & ~((wr_ptr_q == '0) & full_q[wr_bank_q]);
  assign wr_drop = Data_valid_in & ~wr_acc;
  assign wr_last = wr_acc & (wr_ptr_q == LAST);
  assign cp_cur  = (sym_idx_q == '0 || sym_idx_q == SW'(SYMS_PER_HALF)) ? CP_L : CP_S;

  // A bank completing this cycle is readable immediately so output starts at last-write+2.
  always_comb begin
    avail = full_q;
    cp_av = cp_len_q;
    if (wr_last) begin
      avail[wr_bank_q] = 1'b1;
      cp_av[wr_bank_q] = cp_cur;
    end
  end

  assign start_rd  = AW'(0) - AW'(cp_av[rd_bank_q]);
  assign start_nxt = AW'(0) - AW'(cp_av[~rd_bank_q]);

  // Reader next-state: IDLE issues the first CP read itself; BODY chains into CP with no gap.
  always_comb begin
    st_d         = st_q;
    rd_ptr_d     = rd_ptr_q;
    rd_bank_d    = rd_bank_q;
    first_pend_d = first_pend_q;
    rd_addr      = rd_ptr_q;
    rd_en        = 1'b0;
    rd_first     = 1'b0;
    rd_clr       = 1'b0;
    case (st_q)
      IDLE: if (avail[rd_bank_q]) begin
        rd_en    = 1'b1;
        rd_first = 1'b1;
        rd_addr  = start_rd;
        if (start_rd == LAST) begin
          st_d     = BODY;
          rd_ptr_d = '0;
        end else begin
          st_d     = CP;
          rd_ptr_d = start_rd + AW'(1);
        end
      end
      CP: begin
        rd_en        = 1'b1;
        rd_first     = first_pend_q;
        first_pend_d = 1'b0;
        if (rd_ptr_q == LAST) begin
          st_d     = BODY;
          rd_ptr_d = '0;
        end else begin
          rd_ptr_d = rd_ptr_q + AW'(1);
        end
      end
      BODY: begin
        rd_en = 1'b1;
        if (rd_ptr_q == LAST) begin
          rd_clr    = 1'b1;
          rd_bank_d = ~rd_bank_q;
          if (avail[~rd_bank_q]) begin
            st_d         = CP;
            rd_ptr_d     = start_nxt;
            first_pend_d = 1'b1;
          end else begin
            st_d     = IDLE;
            rd_ptr_d = '0;
          end
        end else begin
          rd_ptr_d = rd_ptr_q + AW'(1);
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // Set and clear target different banks, so both always take effect.
  always_comb begin
    full_d = full_q;
    if (rd_clr)  full_d[rd_bank_q] = 1'b0;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
  end

  // Writer pointer, bank, symbol index and slot alignment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      wr_bank_q   <= 1'b0;
      full_q      <= '0;
      cp_len_q[0] <= '0;
      cp_len_q[1] <= '0;
      sym_idx_q   <= '0;
      sync_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (wr_drop) overflow_q <= 1'b1;
      if (wr_last) begin
        wr_bank_q           <= ~wr_bank_q;
        cp_len_q[wr_bank_q] <= cp_cur;
        sync_pend_q         <= 1'b0;
        if (sync_pend_q || slot_sync || sym_idx_q == SW'(SYMS_PER_SLOT - 1))
          sym_idx_q <= '0;
        else
          sym_idx_q <= sym_idx_q + SW'(1);
      end else if (slot_sync) begin
        // mid-symbol sync is deferred to the symbol that follows
        if (wr_ptr_q == '0 && !wr_acc) sym_idx_q <= '0;
        else sync_pend_q <= 1'b1;
      end
    end
  end

  // Reader state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q         <= IDLE;
      rd_ptr_q     <= '0;
      rd_bank_q    <= 1'b0;
      first_pend_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_bank_q    <= rd_bank_d;
      first_pend_q <= first_pend_d;
    end
  end

  pusch_cp_bank_ram #(.DW(2*WIDTH), .AW(AW+1)) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i ({wr_bank_q, wr_ptr_q}),
    .wdata_i ({Data_r_in, Data_i_in}),
    .re_i    (rd_en),
    .raddr_i ({rd_bank_q, rd_addr}),
    .rdata_o (rdata)
  );

  // Two-stage output: RAM latency then registered output; data zeroed when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
      dout_q       <= '0;
    end else begin
      vld_pipe_q   <= {vld_pipe_q[1], rd_en};
      first_pipe_q <= {first_pipe_q[1], rd_first};
      dout_q       <= vld_pipe_q[1] ? rdata : '0;
    end
  end

  assign Data_valid = vld_pipe_q[2];
  assign sym_first  = first_pipe_q[2];
  assign Data_r     = dout_q.re;
  assign Data_i     = dout_q.im;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_pusch_cp_insert.sv
// Directed bench for pusch_cp_insert with NFFT=16, CP_LEN=4, CP_EXT=1.
module tb_pusch_cp_insert;
  localparam int W = 26;
  localparam int N = 16;

  logic clk = 0, reset = 1, slot_sync = 0, vin = 0;
  logic signed [W-1:0] rin = 0, iin = 0;
  logic dv, sf, ovf;
  logic signed [W-1:0] dr, di;
  int n_chk = 0, n_err = 0, cyc = 0, last_c = 0;

  typedef struct { int re; int im; bit first; int c; } osmp_t;
  osmp_t oq[$];

  typedef struct {
    string nm;
    int    nsym;
    int    gap[15];
    int    cp[15];
    bit    contig;
  } row_t;
  row_t rows[3];

  pusch_cp_insert #(.WIDTH(W), .NFFT(N), .CP_LEN(4), .CP_EXT(1),
                    .SYMS_PER_SLOT(14), .SYMS_PER_HALF(7)) dut (
    .clk(clk), .reset(reset), .slot_sync(slot_sync), .Data_valid_in(vin),
    .Data_r_in(rin), .Data_i_in(iin), .Data_valid(dv), .Data_r(dr),
    .Data_i(di), .sym_first(sf), .overflow(ovf));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dv === 1'b1) oq.push_back('{int'(dr), int'(di), sf, cyc});

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic sync_pulse();
    slot_sync = 1; idle(1); slot_sync = 0;
  endtask

  task automatic wr_sym(input int base, output int lc);
    for (int k = 0; k < N; k++) begin
      vin = 1; rin = W'(base + k); iin = W'(-(base + k));
      if (k == N - 1) lc = cyc;
      idle(1);
    end
    vin = 0; rin = 0; iin = 0;
  endtask

  task automatic check_out(input string tag, input int n, input int cps[15],
                           input int base, input bit contig);
    int idx, prev_c, bad, len, v;
    idx = 0; prev_c = 0;
    for (int s = 0; s < n; s++) begin
      len = N + cps[s];
      if (idx + len > oq.size()) begin
        chk($sformatf("%s_s%0d_len", tag, s), oq.size(), idx + len);
        return;
      end
      chk($sformatf("%s_s%0d_first", tag, s), oq[idx].first, 1);
      chk($sformatf("%s_s%0d_contig", tag, s), oq[idx+len-1].c, oq[idx].c + len - 1);
      if (contig && s > 0) chk($sformatf("%s_s%0d_nogap", tag, s), oq[idx].c, prev_c + 1);
      bad = 0;
      for (int j = 0; j < len; j++) begin
        v = base + ((j < cps[s]) ? (N - cps[s] + j) : (j - cps[s]));
        if (oq[idx+j].re != v || oq[idx+j].im != -v || (j > 0 && oq[idx+j].first)) bad++;
      end
      chk($sformatf("%s_s%0d_data", tag, s), bad, 0);
      prev_c = oq[idx+len-1].c;
      idx += len;
    end
    chk({tag, "_total"}, oq.size(), idx);
  endtask

  initial begin
    rows[0].nm = "sym0"; rows[0].nsym = 1;  rows[0].contig = 0;
    rows[0].gap = '{default:0};
    rows[0].cp  = '{0:5, default:0};
    rows[1].nm = "b2b";  rows[1].nsym = 3;  rows[1].contig = 1;
    rows[1].gap = '{0:0, 1:0, 2:8, default:0};
    rows[1].cp  = '{0:5, 1:4, 2:4, default:0};
    rows[2].nm = "slot"; rows[2].nsym = 15; rows[2].contig = 0;
    rows[2].gap = '{default:8};
    rows[2].cp  = '{5,4,4,4,4,4,4,5,4,4,4,4,4,4,5};

    // reset state
    reset = 1; idle(3);
    chk("rst_valid", dv, 0); chk("rst_r", dr, 0); chk("rst_i", di, 0);
    chk("rst_first", sf, 0); chk("rst_ovf", ovf, 0);
    reset = 0; idle(2);

    // table rows
    for (int r = 0; r < 3; r++) begin
      sync_pulse();
      oq.delete();
      for (int s = 0; s < rows[r].nsym; s++) begin
        idle(rows[r].gap[s]);
        wr_sym(0, last_c);
        if (r == 0 && s == 0) begin
          idle(3);
          chk("sym0_latency", (oq.size() > 0) ? oq[0].c : -1, last_c + 2);
        end
      end
      idle(40);
      check_out(rows[r].nm, rows[r].nsym, rows[r].cp, 0, rows[r].contig);
      chk({rows[r].nm, "_ovf"}, ovf, 0);
    end

    // continuous input: third symbol's first sample hits a full bank
    sync_pulse();
    for (int k = 0; k < 3 * N; k++) begin
      vin = 1; rin = W'(k % N); iin = W'(-(k % N));
      idle(1);
      if (k == 2 * N - 1) chk("ovf_before_drop", ovf, 0);
      if (k == 2 * N)     chk("ovf_on_drop", ovf, 1);
    end
    vin = 0; rin = 0; iin = 0;
    idle(60);
    chk("ovf_sticky", ovf, 1);

    // reset asserted in the middle of a CP
    reset = 1; idle(2); reset = 0; idle(2);
    chk("ovf_cleared", ovf, 0);
    sync_pulse();
    wr_sym(0, last_c);
    idle(3);
    chk("cp_active", dv, 1);
    #2 reset = 1;
    #1;
    chk("async_valid", dv, 0); chk("async_r", dr, 0); chk("async_i", di, 0);
    chk("async_first", sf, 0);
    idle(2); reset = 0; idle(2);
    oq.delete();
    wr_sym(64, last_c);
    idle(40);
    check_out("postrst", 1, rows[0].cp, 64, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
